crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
- Parametrised serial/parallel CRC engine over multi-word frames.
- Accepts DATA_W-bit words on a valid/ready handshake and folds BPC bits per cycle into a CRC_W-bit register, MSB first.
- On the word flagged last, it presents the finalised CRC for one cycle, flags residue match (check mode), and re-arms for the next frame.
- Successor to the byte-wide CRC-8 helper: adds configurable width, polynomial, init, xor-out, bits per cycle, frame handling and backpressure. Sits between the packet framer and the link transmitter/receiver.

Parameters:
- CRC_W, 8, CRC register width (2..32).
- POLY, 8'h07, generator polynomial without the implicit x^CRC_W term.
- INIT, 0, register value at frame start, after rst and after clr.
- XOR_OUT, 0, value XORed into the register to form crc_out.
- RESIDUE, 0, raw register value meaning "frame plus appended CRC is good".
- DATA_W, 8, input word width.
- BPC, 1, bits folded per cycle. Must divide DATA_W. K = DATA_W/BPC cycles per word.

Ports:
- clk, in, 1, clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- clr, in, 1, synchronous abort: discard frame, reload INIT.
- in_valid, in, 1, in_data/in_last valid.
- in_ready, out, 1, engine can accept a word this cycle.
- in_data, in, DATA_W, data word; bit DATA_W-1 is processed first.
- in_last, in, 1, this word ends the frame.
- crc_out, out, CRC_W, finalised CRC of the last completed frame.
- crc_valid, out, 1, one-cycle pulse: crc_out/match updated.
- match, out, 1, raw final register == RESIDUE; qualified by crc_valid.
- busy, out, 1, state != IDLE or a frame is partially accumulated.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, crc_reg=INIT, crc_out=0, crc_valid=0, match=0, partial-frame flag=0.
  - in_ready=1 from the first cycle after reset.
- Priority: rst > clr > handshake.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into a shift register, latch in_last, set chunk counter=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle fold the top BPC bits MSB-first into crc_reg: per bit, fb = crc_reg[CRC_W-1]^d; crc_reg = (crc_reg<<1) ^ (fb ? POLY : 0). Then shift data left by BPC and increment the counter.
    - After the K-th cycle: if last was latched, go to DONE; otherwise go to IDLE and keep crc_reg.
  - DONE, one cycle: in_ready=0.
    - crc_out <= crc_reg^XOR_OUT; match <= (crc_reg==RESIDUE); crc_valid=1 this cycle only.
    - crc_reg <= INIT; partial flag cleared; next state IDLE.
- Latency: word accepted at edge t. Its last chunk is folded at edge t+K. For a last word, crc_valid is high in the cycle following edge t+K+1 (registered outputs).
- Throughput: one word per K+1 cycles. in_valid may be held across the stall. in_data/in_last are sampled only on the handshake.
- crc_out and match hold their values until the next DONE. crc_valid never lasts more than one cycle.
- clr in any state:
  - Next cycle is IDLE with crc_reg=INIT, partial flag cleared, crc_valid=0.
  - Any in-flight word is discarded; crc_out/match are unchanged.
  - A handshake in the same cycle as clr is ignored.
- Zero-length frames do not exist: a single word with in_last=1 is a one-word frame.
- rst or clr mid-frame leaves no residue; the next frame starts from INIT.
- in_valid while in_ready=0 has no effect. The source must hold the word (standard valid/ready).
- Elaboration check: DATA_W % BPC != 0 or CRC_W out of range is a fatal error.

Test Plan:
- Default params; ASCII "123456789" (0x31..0x39), in_last on 0x39 -> crc_valid pulse, crc_out=0xF4. Each word has in_ready low for exactly K=8 cycles after acceptance.
- Single word 0x01, last=1 -> crc_out=0x07. Then 0x00, last=1 -> crc_out=0x00, confirming re-arm to INIT between frames.
- BPC=8 and BPC=4, same "123456789" -> crc_out=0xF4. Per-word stall is 1 and 2 cycles respectively.
- Check mode: "123456789" followed by 0xF4 with last=1 -> crc_valid=1, match=1. With 0xF5 as the final word -> match=0.
- Abort: send 0x31,0x32, pulse clr mid-SHIFT, then "123456789" -> no crc_valid before the final frame, crc_out=0xF4. Repeat the sequence with rst in place of clr: crc_out=0x00 until done, then 0xF4.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, "123456789" -> crc_out=0x29B1. in_valid held high throughout with random stalls -> same result.

Source files
------------

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts words on valid/ready, folds BPC bits per cycle MSB-first,
// and emits the finalised CRC plus a residue-match flag when the frame's last word completes.
module crc_stream_engine #(
  parameter int              CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'('h07),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0,
  parameter int              DATA_W  = 8,
  parameter int              BPC     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              match,
  output logic              busy
);

  localparam int K     = DATA_W / BPC;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  generate
    if (CRC_W < 2 || CRC_W > 32 || BPC < 1 || (DATA_W % BPC) != 0) begin : g_param_check
      $fatal(1, "crc_stream_engine: CRC_W must be 2..32 and BPC must divide DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CRC_W-1:0]   crc_reg, crc_next, crc_fold;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               last_reg, last_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               partial_reg, partial_next;
  logic [CRC_W-1:0]   crc_out_reg, crc_out_next;
  logic               match_reg, match_next;
  logic               valid_reg, valid_next;
  logic               fold_bit;

  // Fold the top BPC data bits into the register, one polynomial step per bit.
  always_comb begin
    crc_fold = crc_reg;
    fold_bit = 1'b0;
    for (int b = 0; b < BPC; b++) begin
      fold_bit = crc_fold[CRC_W-1] ^ data_reg[DATA_W-1-b];
      crc_fold = {crc_fold[CRC_W-2:0], 1'b0} ^ (fold_bit ? POLY : '0);
    end
  end

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    data_next    = data_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    partial_next = partial_reg;
    crc_out_next = crc_out_reg;
    match_next   = match_reg;
    valid_next   = 1'b0;
    if (clr) begin
      // Abort wins over any handshake or finalisation in this cycle.
      state_next   = IDLE;
      crc_next     = INIT;
      partial_next = 1'b0;
      cnt_next     = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_next    = in_data;
            last_next    = in_last;
            cnt_next     = '0;
            partial_next = 1'b1;
            state_next   = SHIFT;
          end
        end
        SHIFT: begin
          crc_next  = crc_fold;
          data_next = data_reg << BPC;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(K - 1)) begin
            state_next = last_reg ? DONE : IDLE;
          end
        end
        DONE: begin
          crc_out_next = crc_reg ^ XOR_OUT;
          match_next   = (crc_reg == RESIDUE);
          valid_next   = 1'b1;
          crc_next     = INIT;
          partial_next = 1'b0;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      crc_reg     <= INIT;
      data_reg    <= '0;
      last_reg    <= 1'b0;
      cnt_reg     <= '0;
      partial_reg <= 1'b0;
      crc_out_reg <= '0;
      match_reg   <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      data_reg    <= data_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      partial_reg <= partial_next;
      crc_out_reg <= crc_out_next;
      match_reg   <= match_next;
      valid_reg   <= valid_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign crc_out   = crc_out_reg;
  assign crc_valid = valid_reg;
  assign match     = match_reg;
  assign busy      = (state_reg != IDLE) || partial_reg;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: four instances (CRC-8 at BPC 1/8/4, CRC-16/CCITT-FALSE) checked
// every cycle against a frame-level model of handshake timing, CRC value and residue match.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr;
  logic        in_valid [4];
  logic [7:0]  in_data  [4];
  logic        in_last  [4];
  logic        in_ready [4];
  logic        crc_valid[4];
  logic        match    [4];
  logic        busy     [4];
  logic [7:0]  co0, co1, co2;
  logic [15:0] co3;
  logic [31:0] crc_out_a[4];

  assign crc_out_a[0] = {24'd0, co0};
  assign crc_out_a[1] = {24'd0, co1};
  assign crc_out_a[2] = {24'd0, co2};
  assign crc_out_a[3] = {16'd0, co3};

  crc_stream_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00),
                      .DATA_W(8), .BPC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .crc_out(co0), .crc_valid(crc_valid[0]),
    .match(match[0]), .busy(busy[0]));

  crc_stream_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00),
                      .DATA_W(8), .BPC(8)) u_bpc8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .crc_out(co1), .crc_valid(crc_valid[1]),
    .match(match[1]), .busy(busy[1]));

  crc_stream_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00),
                      .DATA_W(8), .BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_last(in_last[2]), .crc_out(co2), .crc_valid(crc_valid[2]),
    .match(match[2]), .busy(busy[2]));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
                      .RESIDUE(16'h0000), .DATA_W(8), .BPC(1)) u_crc16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .in_last(in_last[3]), .crc_out(co3), .crc_valid(crc_valid[3]),
    .match(match[3]), .busy(busy[3]));

  // Per-instance configuration as seen by the model.
  int          cw   [4];
  logic [31:0] cpoly[4];
  logic [31:0] cinit[4];
  int          kk   [4];

  // Model state.
  int          hold   [4];
  int          vcd    [4];
  bit          show   [4];
  bit          hs_flag[4];
  logic [31:0] exp_crc[4], pend_crc[4];
  bit          exp_match[4], pend_match[4];
  logic [7:0]  fbuf   [4][32];
  int          flen   [4];
  bit          armed;

  int          n_cmp, n_bad;
  logic [7:0]  msg [16];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw register after folding a byte frame, straight from the polynomial-division definition.
  function automatic logic [31:0] crc_raw(int i, int n);
    logic [31:0] r, mask;
    bit fb;
    mask = (cw[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[i]) - 32'd1);
    r = cinit[i];
    for (int j = 0; j < n; j++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[cw[i]-1] ^ fbuf[i][j][b];
        r = ((r << 1) & mask) ^ (fb ? cpoly[i] : 32'd0);
      end
    end
    return r;
  endfunction

  // Compare this cycle's outputs, then advance the model by the inputs the next edge will see.
  task automatic model_cycle();
    bit hs;
    for (int i = 0; i < 4; i++) begin
      if (armed) begin
        check($sformatf("in_ready[%0d]", i), {31'd0, in_ready[i]}, {31'd0, hold[i] == 0});
        check($sformatf("crc_valid[%0d]", i), {31'd0, crc_valid[i]}, {31'd0, show[i]});
        check($sformatf("busy[%0d]", i), {31'd0, busy[i]}, {31'd0, (hold[i] > 0) || (flen[i] > 0)});
        check($sformatf("crc_out[%0d]", i), crc_out_a[i], exp_crc[i]);
        check($sformatf("match[%0d]", i), {31'd0, match[i]}, {31'd0, exp_match[i]});
      end
      hs = in_valid[i] && (hold[i] == 0) && !clr && !rst;
      hs_flag[i] = hs;
      if (rst) begin
        hold[i] = 0; vcd[i] = 0; show[i] = 0; flen[i] = 0;
        exp_crc[i] = 32'd0; exp_match[i] = 1'b0;
      end else if (clr) begin
        hold[i] = 0; vcd[i] = 0; show[i] = 0; flen[i] = 0;
      end else begin
        show[i] = 0;
        if (vcd[i] > 0) begin
          vcd[i]--;
          if (vcd[i] == 0) begin
            show[i] = 1;
            exp_crc[i] = pend_crc[i];
            exp_match[i] = pend_match[i];
          end
        end
        if (hold[i] > 0) hold[i]--;
        if (hs) begin
          fbuf[i][flen[i]] = in_data[i];
          flen[i]++;
          if (in_last[i]) begin
            pend_crc[i] = crc_raw(i, flen[i]);   // XOR_OUT and RESIDUE are zero everywhere
            pend_match[i] = (pend_crc[i] == 32'd0);
            flen[i] = 0;
            vcd[i] = kk[i] + 1;
            hold[i] = kk[i] + 1;
          end else begin
            hold[i] = kk[i];
          end
        end
      end
    end
    if (rst) armed = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic send(int i, logic [7:0] d, logic last, bit keep);
    bit done;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_last[i]  = last;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      done = hs_flag[i];
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout[%0d]: got no acceptance, expected one within 100 cycles", i);
    end
    if (!keep) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 8'hA5;
      in_last[i]  = 1'b1;
    end
  endtask

  task automatic send_frame(int i, int n, bit keep, bit gaps);
    for (int j = 0; j < n; j++) begin
      if (gaps) begin
        in_valid[i] = 1'b0;
        in_data[i]  = 8'h5A;
        idle($urandom_range(0, 3));
      end
      send(i, msg[j], (j == n - 1), keep);
    end
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    idle(kk[i] + 4);
  endtask

  task automatic load_ascii();
    for (int j = 0; j < 9; j++) msg[j] = 8'h31 + 8'(j);
  endtask

  task automatic pulse(bit use_rst);
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    step();
    rst = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; armed = 0;
    cw    = '{8, 8, 8, 16};
    cpoly = '{32'h07, 32'h07, 32'h07, 32'h1021};
    cinit = '{32'h00, 32'h00, 32'h00, 32'hFFFF};
    kk    = '{8, 1, 2, 8};
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 0; in_data[i] = 0; in_last[i] = 0;
      hold[i] = 0; vcd[i] = 0; show[i] = 0; flen[i] = 0; hs_flag[i] = 0;
      exp_crc[i] = 0; exp_match[i] = 0; pend_crc[i] = 0; pend_match[i] = 0;
    end
    rst = 1'b1;
    clr = 1'b0;

    // Pin the model against published check values.
    load_ascii();
    for (int j = 0; j < 9; j++) begin fbuf[0][j] = msg[j]; fbuf[3][j] = msg[j]; end
    check("model_crc8_123456789", crc_raw(0, 9), 32'hF4);
    check("model_crc16_123456789", crc_raw(3, 9), 32'h29B1);
    fbuf[0][0] = 8'h01;
    check("model_crc8_01", crc_raw(0, 1), 32'h07);

    idle(3);
    rst = 1'b0;
    check("reset_crc_out", crc_out_a[0], 32'h0);

    // Basic frame, BPC=1.
    send_frame(0, 9, 0, 0);
    check("ascii_bpc1", crc_out_a[0], 32'hF4);

    // One-word frames and re-arm to INIT.
    msg[0] = 8'h01; send_frame(0, 1, 0, 0);
    check("single_01", crc_out_a[0], 32'h07);
    msg[0] = 8'h00; send_frame(0, 1, 0, 0);
    check("single_00", crc_out_a[0], 32'h00);

    // Wider folds.
    load_ascii();
    send_frame(1, 9, 0, 0);
    check("ascii_bpc8", crc_out_a[1], 32'hF4);
    send_frame(2, 9, 0, 0);
    check("ascii_bpc4", crc_out_a[2], 32'hF4);

    // Check mode: good and corrupted appended CRC.
    msg[9] = 8'hF4; send_frame(0, 10, 0, 0);
    check("residue_good_match", {31'd0, match[0]}, 32'd1);
    msg[9] = 8'hF5; send_frame(0, 10, 0, 0);
    check("residue_bad_match", {31'd0, match[0]}, 32'd0);
    check("residue_bad_crc", crc_out_a[0], 32'h07);

    // Abort mid-word with clr, then with rst.
    for (int r = 0; r < 2; r++) begin
      send(0, 8'h31, 1'b0, 0);
      send(0, 8'h32, 1'b0, 0);
      idle(3);
      pulse(r == 1);
      if (r == 1) check("after_rst_crc_out", crc_out_a[0], 32'h00);
      send_frame(0, 9, 0, 0);
      check($sformatf("after_abort%0d", r), crc_out_a[0], 32'hF4);
    end

    // CRC-16: valid held high back-to-back, then with random gaps.
    send_frame(3, 9, 1, 0);
    check("crc16_held", crc_out_a[3], 32'h29B1);
    send_frame(3, 9, 0, 1);
    check("crc16_gaps", crc_out_a[3], 32'h29B1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
